stream_mux_n: RTL and testbench
===============================

# stream_mux_n

Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshaking and a one-entry registered output stage. It replaces fixed 3:1 combinational operand selection in the autoencoder datapath (weight, activation and bias feeds into the MAC) with a backpressure-aware selector. Channel choice is either an explicit select or round-robin arbitration, and out-of-range selects are flagged.

## Interface
- WIDTH, 16, data width per channel
- N_IN, 4, number of input channels (2..16)
- SEL_W, $clog2(N_IN), select/channel-index width (N_IN=2 gives 1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N_IN  per-channel valid
- in_ready  output  N_IN  per-channel ready, combinational, at most one bit high
- mode  input  1  0 = fixed select, 1 = round-robin
- select  input  SEL_W  channel index used in fixed mode
- out_data  output  WIDTH  registered output data
- out_chan  output  SEL_W  channel index of out_data
- out_valid  output  1  output holds a word
- out_ready  input  1  downstream accepts
- err_clr  input  1  clears err_sel
- err_sel  output  1  sticky flag: out-of-range select was seen in fixed mode
- xfer_cnt  output  16  accepted output transfers. Only present when STREAM_MUX_CNT_EN is defined.

## Operation
- load_en = !out_valid || out_ready. The output stage may accept a new word only when load_en is high.
- Fixed mode: the candidate is select.
  - If select >= N_IN: no grant, all in_ready are low, and err_sel sets every cycle the condition holds.
  - Otherwise grant = select when in_valid[select] is high.
- Round-robin mode: search from (rr_ptr+1) mod N_IN upward with wrap. Grant the first channel whose in_valid is high.
- rr_ptr updates to the granted index only on an actual transfer. Fixed-mode grants do not move rr_ptr.
- in_ready[g] = load_en && grant_valid && (g == grant). in_ready never depends on in_valid of other channels beyond the arbitration itself.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - out_data <= channel g data
  - out_chan <= g
  - out_valid <= 1
- Output handshake: out_valid && out_ready with no new grant gives out_valid <= 0. While out_valid && !out_ready, out_data and out_chan hold stable.
- Mode or select changes take effect on the next arbitration cycle. A word already in the output register is unaffected.
- err_sel: set has priority over err_clr in the same cycle.
- Reset values:
  - out_valid = 0, out_data = 0, out_chan = 0, err_sel = 0
  - rr_ptr = N_IN-1, so the first round-robin grant goes to channel 0
  - xfer_cnt = 0
- Reset asserted mid-operation discards the buffered word. No transfer is reported for it.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Simultaneous output accept and new grant in the same cycle: the new word replaces the old with out_valid staying 1 (no bubble).
- in_ready, arbitration and err_sel detection are combinational from the current-cycle inputs and registered state. Everything else is registered.

## Configuration
- STREAM_MUX_CNT_EN defined:
  - xfer_cnt port exists.
  - It increments on each out_valid && out_ready cycle and saturates at 16'hFFFF.
  - It resets to 0 on rst_n low.
- STREAM_MUX_CNT_EN undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Fixed mode: N_IN=4, select=2, in_valid=4'b1111, ch2=16'hBEEF, out_ready=1 -> next cycle out_data=16'hBEEF, out_chan=2; only in_ready[2] high.
- Round-robin after reset: all four valid with data 16'h0010..16'h0013 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles after a load -> out_data stable, all in_ready=0. Raise out_ready -> old word accepted, new word loaded the same cycle.
- Round-robin skip: in_valid=4'b1010, rr_ptr=1 -> grant 3, then 1, then 3.
- Error flag: N_IN=3, mode=0, select=3 -> no in_ready, err_sel=1 next cycle. Pulse err_clr with select=0 -> err_sel=0. Pulse err_clr with select=3 still applied -> err_sel stays 1.
- Reset mid-stream (STREAM_MUX_CNT_EN on): 5 accepted transfers, then rst_n low while out_valid=1 -> out_valid=0 and xfer_cnt=0 immediately (asynchronous). The first grant after reset goes to channel 0.

Source files
------------

// File: rtl/stream_mux_n.sv
// ---------------------------------------------------------------------------
// stream_mux_n
//
// Purpose:
//   N-input, WIDTH-bit stream multiplexer with valid/ready handshaking and a
//   one-entry registered output stage. The source channel is picked either by
//   an explicit select (fixed mode) or by round-robin arbitration. A select
//   that points past the last channel is flagged with a sticky error bit.
//
// Optional feature:
//   STREAM_MUX_CNT_EN - when defined, adds the xfer_cnt output, a saturating
//                       count of accepted output transfers.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_data   in   N_IN*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid  in   N_IN per-channel valid
//   in_ready  out  N_IN per-channel ready (combinational, one-hot or zero)
//   mode      in   0 = fixed select, 1 = round-robin
//   select    in   SEL_W channel index used in fixed mode
//   out_data  out  WIDTH registered output word
//   out_chan  out  SEL_W channel the output word came from
//   out_valid out  output register holds a word
//   out_ready in   downstream accepts the output word
//   err_clr   in   clears err_sel (a new error in the same cycle wins)
//   err_sel   out  sticky out-of-range select flag
//   xfer_cnt  out  16-bit accepted-transfer count (STREAM_MUX_CNT_EN only)
// ---------------------------------------------------------------------------
module stream_mux_n #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
`ifdef STREAM_MUX_CNT_EN
    output logic                    err_sel,
    output logic [15:0]             xfer_cnt
`else
    output logic                    err_sel
`endif
);

    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_chan;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic              r_err_sel;

    logic              w_load_en;
    logic              w_grant_valid;
    logic [SEL_W-1:0]  w_grant;
    logic [SEL_W-1:0]  w_idx;
    logic              w_sel_err;
    logic              w_xfer;
    logic [N_IN-1:0]   w_in_ready;

    // The output register can take a new word when it is empty or its
    // current word leaves this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Arbitration. Round-robin starts one past the last granted channel so
    // that a channel which just won gets the lowest priority next time.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_idx         = '0;
        w_sel_err     = 1'b0;
        if (!mode) begin
            if ({1'b0, select} >= (SEL_W+1)'(N_IN)) begin
                w_sel_err = 1'b1;
            end else if (in_valid[select]) begin
                w_grant_valid = 1'b1;
                w_grant       = select;
            end
        end else begin
            for (int k = 1; k <= N_IN; k++) begin
                w_idx = SEL_W'((int'(r_rr_ptr) + k) % N_IN);
                if (!w_grant_valid && in_valid[w_idx]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = w_idx;
                end
            end
        end
    end

    // Ready goes only to the granted channel, and only when the output
    // register can take its word.
    always_comb begin
        w_in_ready = '0;
        if (w_load_en && w_grant_valid) begin
            w_in_ready[w_grant] = 1'b1;
        end
    end

    // A grant always implies the granted channel is valid, so a grant with
    // load_en is an input-side transfer.
    assign w_xfer = w_load_en && w_grant_valid;

    // Output stage and round-robin pointer. A new word overwrites an
    // accepted one in the same cycle, so streaming has no bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= SEL_W'(N_IN - 1);
        end else begin
            if (w_xfer) begin
                r_out_data  <= in_data[int'(w_grant)*WIDTH +: WIDTH];
                r_out_chan  <= w_grant;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_rr_ptr <= w_grant;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Sticky select error; a fresh error outranks a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sel <= 1'b0;
        end else if (w_sel_err) begin
            r_err_sel <= 1'b1;
        end else if (err_clr) begin
            r_err_sel <= 1'b0;
        end
    end

`ifdef STREAM_MUX_CNT_EN
    logic [15:0] r_xfer_cnt;

    // Accepted output transfers, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (r_out_valid && out_ready && (r_xfer_cnt != 16'hFFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_stream_mux_n.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_n
//
// Self-checking bench for stream_mux_n. A four-channel instance is driven
// through fixed, round-robin, backpressure, skip and mid-stream reset
// scenarios; a reference arbiter predicts each grant and pushes the expected
// word into a queue that is popped when the output handshake completes. A
// three-channel instance exercises the out-of-range select flag.
// ---------------------------------------------------------------------------
module tb_stream_mux_n;

    logic        clk;
    logic        rstN;
    logic [63:0] inData;
    logic [3:0]  inValid;
    logic [3:0]  inReady;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] outData;
    logic [1:0]  outChan;
    logic        outValid;
    logic        outReady;
    logic        errClr;
    logic        errSel;

    logic [47:0] e3Data;
    logic [2:0]  e3Valid;
    logic [2:0]  e3Ready;
    logic [1:0]  e3Sel;
    logic [15:0] e3OutData;
    logic [1:0]  e3OutChan;
    logic        e3OutValid;
    logic        e3Clr;
    logic        e3Err;

`ifdef STREAM_MUX_CNT_EN
    logic [15:0] xferCnt;
    logic [15:0] e3XferCnt;
`endif

    int totalCount = 0;
    int badCount   = 0;

    logic [17:0] sbQ[$];
    logic [1:0]  chanLog[$];
    logic [1:0]  modelRr;

    stream_mux_n #(.WIDTH(16), .N_IN(4)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .mode      (mode),
        .select    (sel),
        .out_data  (outData),
        .out_chan  (outChan),
        .out_valid (outValid),
        .out_ready (outReady),
        .err_clr   (errClr),
`ifdef STREAM_MUX_CNT_EN
        .err_sel   (errSel),
        .xfer_cnt  (xferCnt)
`else
        .err_sel   (errSel)
`endif
    );

    stream_mux_n #(.WIDTH(16), .N_IN(3)) dut3 (
        .clk       (clk),
        .rst_n     (rstN),
        .in_data   (e3Data),
        .in_valid  (e3Valid),
        .in_ready  (e3Ready),
        .mode      (1'b0),
        .select    (e3Sel),
        .out_data  (e3OutData),
        .out_chan  (e3OutChan),
        .out_valid (e3OutValid),
        .out_ready (1'b1),
        .err_clr   (e3Clr),
`ifdef STREAM_MUX_CNT_EN
        .err_sel   (e3Err),
        .xfer_cnt  (e3XferCnt)
`else
        .err_sel   (e3Err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        if (obs !== exp) begin
            badCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
        mode     = m;
        sel      = s;
        inValid  = v;
        outReady = r;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setData(input logic [15:0] base);
        for (int i = 0; i < 4; i++) inData[i*16 +: 16] = base + 16'(i);
    endtask

    // Reference model: runs at the falling edge, when inputs are stable for
    // the coming rising edge. Pops on output handshake, then predicts the
    // grant and pushes the word expected to load at that edge.
    always @(negedge clk) begin
        logic       loadEn;
        logic       gv;
        logic [1:0] g;
        logic [1:0] idx;
        logic [17:0] word;
        if (rstN) begin
            loadEn = (sbQ.size() == 0) || outReady;
            checkOutput("out_valid", {31'd0, outValid}, {31'd0, sbQ.size() != 0});
            if (outValid && outReady) begin
                if (sbQ.size() == 0) begin
                    checkOutput("pop_empty", 32'd1, 32'd0);
                end else begin
                    word = sbQ.pop_front();
                    checkOutput("sb_data", {16'd0, outData}, {16'd0, word[15:0]});
                    checkOutput("sb_chan", {30'd0, outChan}, {30'd0, word[17:16]});
                    chanLog.push_back(outChan);
                end
            end
            gv = 1'b0;
            g  = 2'd0;
            if (!mode) begin
                gv = inValid[sel];
                g  = sel;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    idx = modelRr + 2'(k);
                    if (!gv && inValid[idx]) begin
                        gv = 1'b1;
                        g  = idx;
                    end
                end
            end
            checkOutput("in_ready", {28'd0, inReady}, (loadEn && gv) ? (32'd1 << g) : 32'd0);
            if (loadEn && gv) begin
                sbQ.push_back({g, inData[g*16 +: 16]});
                if (mode) modelRr = g;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic doReset();
        rstN = 1'b0;
        tick(2);
        sbQ.delete();
        modelRr = 2'd3;
        rstN = 1'b1;
    endtask

    initial begin
        rstN    = 1'b0;
        inData  = '0;
        errClr  = 1'b0;
        e3Data  = {16'h3002, 16'h3001, 16'h3000};
        e3Valid = 3'b111;
        e3Sel   = 2'd0;
        e3Clr   = 1'b0;
        modelRr = 2'd3;
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
        tick(2);
        checkOutput("rst_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_data",  {16'd0, outData}, 32'd0);
        checkOutput("rst_chan",  {30'd0, outChan}, 32'd0);
        checkOutput("rst_err",   {31'd0, errSel}, 32'd0);
`ifdef STREAM_MUX_CNT_EN
        checkOutput("rst_cnt",   {16'd0, xferCnt}, 32'd0);
`endif
        rstN = 1'b1;
        tick(1);

        // Fixed select of channel 2
        setData(16'hA000);
        inData[2*16 +: 16] = 16'hBEEF;
        applyStimulus(1'b0, 2'd2, 4'b1111, 1'b1);
        #1;
        checkOutput("fix_ready", {28'd0, inReady}, 32'h4);
        tick(1);
        checkOutput("fix_data", {16'd0, outData}, 32'hBEEF);
        checkOutput("fix_chan", {30'd0, outChan}, 32'd2);
        inValid = 4'b0000;
        tick(2);

        // Round-robin from reset
        doReset();
        setData(16'h0010);
        chanLog.delete();
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        tick(5);
        inValid = 4'b0000;
        tick(2);
        checkOutput("rr_count", chanLog.size(), 32'd5);
        for (int i = 0; i < 5 && i < chanLog.size(); i++)
            checkOutput($sformatf("rr_seq%0d", i), {30'd0, chanLog[i]}, 32'(i % 4));

        // Backpressure: pointer is at 0, so the next grant is channel 1
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b0);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_data",  {16'd0, outData}, 32'h0011);
            checkOutput("bp_ready", {28'd0, inReady}, 32'd0);
            tick(1);
        end
        outReady = 1'b1;
        tick(1);
        checkOutput("bp_new_data", {16'd0, outData}, 32'h0012);
        checkOutput("bp_new_chan", {30'd0, outChan}, 32'd2);
        inValid = 4'b0000;
        tick(2);

        // Skip over idle channels with the pointer parked on 1
        chanLog.delete();
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1);
        tick(1);
        inValid = 4'b1010;
        tick(3);
        inValid = 4'b0000;
        tick(2);
        checkOutput("skip_count", chanLog.size(), 32'd4);
        if (chanLog.size() == 4) begin
            checkOutput("skip0", {30'd0, chanLog[1]}, 32'd3);
            checkOutput("skip1", {30'd0, chanLog[2]}, 32'd1);
            checkOutput("skip2", {30'd0, chanLog[3]}, 32'd3);
        end

        // Out-of-range select on the three-channel instance
        e3Sel = 2'd3;
        #1;
        checkOutput("err_noready", {29'd0, e3Ready}, 32'd0);
        tick(1);
        checkOutput("err_set", {31'd0, e3Err}, 32'd1);
        e3Sel = 2'd0;
        e3Clr = 1'b1;
        tick(1);
        e3Clr = 1'b0;
        checkOutput("err_clr", {31'd0, e3Err}, 32'd0);
        e3Sel = 2'd3;
        tick(1);
        e3Clr = 1'b1;
        tick(1);
        e3Clr = 1'b0;
        checkOutput("err_prio", {31'd0, e3Err}, 32'd1);
        e3Sel = 2'd0;

        // Reset while a word is buffered
        doReset();
        setData(16'h0010);
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        tick(6);
        checkOutput("mid_valid_before", {31'd0, outValid}, 32'd1);
`ifdef STREAM_MUX_CNT_EN
        checkOutput("mid_cnt_before", {16'd0, xferCnt}, 32'd5);
`endif
        rstN = 1'b0;
        #1;
        checkOutput("mid_valid_after", {31'd0, outValid}, 32'd0);
`ifdef STREAM_MUX_CNT_EN
        checkOutput("mid_cnt_after", {16'd0, xferCnt}, 32'd0);
`endif
        tick(1);
        sbQ.delete();
        modelRr = 2'd3;
        rstN = 1'b1;
        tick(1);
        checkOutput("post_rst_chan", {30'd0, outChan}, 32'd0);
        checkOutput("post_rst_data", {16'd0, outData}, 32'h0010);
        inValid = 4'b0000;
        tick(3);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
